bilinear_interp: RTL and testbench

BILINEAR_INTERP -- requirements
Module: bilinear_interp

---
 rtl/bilinear_interp.sv | 131 +++++++++++++
 tb/tb_bilinear_interp.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bilinear_interp.sv
// Bilinear interpolation of a 2x2 pixel neighbourhood.
// The block is a three-stage pipeline:
//   1. horizontal blend, giving top and bot
//   2. vertical blend, giving acc
//   3. normalise and saturate
// Its output is an AXI-Stream-style pixel stream. m_tlast marks the last
// pixel of each row of img_width pixels.
// Optional feature: define BILINEAR_ROUND_EN to round half up in stage 3.
// When it is undefined, stage 3 truncates and no rounding adder is built.
module bilinear_interp #(
    parameter int img_width = 16,
    parameter int FRAC_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        lu,
    input  logic [7:0]        ru,
    input  logic [7:0]        ld,
    input  logic [7:0]        rd,
    input  logic [FRAC_W-1:0] xfrac,
    input  logic [FRAC_W-1:0] yfrac,
    output logic [7:0]        m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);

    localparam int TOP_W = 8 + FRAC_W + 1;
    localparam int ACC_W = 8 + 2 * FRAC_W + 2;
    localparam int CNT_W = (img_width > 1) ? $clog2(img_width) : 1;
    localparam logic [CNT_W-1:0]  COL_LAST = CNT_W'(img_width - 1);
    localparam logic [FRAC_W:0]   ONE_W    = {1'b1, {FRAC_W{1'b0}}};

    // Scale acc back to pixel range (weights sum to 2^(2*FRAC_W)).
    function automatic logic [ACC_W-1:0] round_shift(input logic [ACC_W-1:0] a);
`ifdef BILINEAR_ROUND_EN
        logic [ACC_W:0] s;
        s = {1'b0, a} + ((ACC_W + 1)'(1) << (2 * FRAC_W - 1));
        return ACC_W'(s >> (2 * FRAC_W));
`else
        return a >> (2 * FRAC_W);
`endif
    endfunction

    // Clamp to the 8-bit pixel range.
    function automatic logic [7:0] sat8(input logic [ACC_W-1:0] v);
        return (v > ACC_W'(255)) ? 8'hFF : v[7:0];
    endfunction

    logic              stall;
    logic              adv;
    logic              vld_p0_q, vld_p0_d;
    logic              vld_p1_q, vld_p1_d;
    logic              vld_p2_q, vld_p2_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [7:0]        tdata_p2_q, tdata_p2_d;
    logic [TOP_W-1:0]  top_p0_q, top_p0_d;
    logic [TOP_W-1:0]  bot_p0_q, bot_p0_d;
    logic [FRAC_W-1:0] yfrac_p0_q, yfrac_p0_d;
    logic [ACC_W-1:0]  acc_p1_q, acc_p1_d;
    logic [FRAC_W:0]   wx_inv;
    logic [FRAC_W:0]   wy_inv;

    assign stall    = vld_p2_q && !m_tready;
    assign adv      = !stall;
    assign in_ready = rst && !stall;
    assign m_tvalid = vld_p2_q;
    assign m_tdata  = tdata_p2_q;
    assign m_tlast  = vld_p2_q && (col_q == COL_LAST);

    // Next-state for the whole pipeline; everything holds while stalled.
    always_comb begin
        wx_inv     = ONE_W - {1'b0, xfrac};
        wy_inv     = ONE_W - {1'b0, yfrac_p0_q};
        // ---- stage 1: horizontal blend ----
        top_p0_d   = TOP_W'(lu) * TOP_W'(wx_inv) + TOP_W'(ru) * TOP_W'(xfrac);
        bot_p0_d   = TOP_W'(ld) * TOP_W'(wx_inv) + TOP_W'(rd) * TOP_W'(xfrac);
        yfrac_p0_d = yfrac;
        // ---- stage 2: vertical blend ----
        acc_p1_d   = ACC_W'(top_p0_q) * ACC_W'(wy_inv)
                   + ACC_W'(bot_p0_q) * ACC_W'(yfrac_p0_q);
        // ---- stage 3: normalise and saturate ----
        tdata_p2_d = sat8(round_shift(acc_p1_q));

        vld_p0_d = vld_p0_q;
        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        if (adv) begin
            vld_p0_d = in_valid && in_ready;
            vld_p1_d = vld_p0_q;
            vld_p2_d = vld_p1_q;
        end

        col_d = col_q;
        if (vld_p2_q && m_tready) begin
            col_d = (col_q == COL_LAST) ? '0 : col_q + CNT_W'(1);
        end
    end

    // Control state and output pixel register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0_q   <= 1'b0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            col_q      <= '0;
            tdata_p2_q <= 8'd0;
        end else begin
            vld_p0_q   <= vld_p0_d;
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            col_q      <= col_d;
            if (adv) begin
                tdata_p2_q <= tdata_p2_d;
            end
        end
    end

    // Intermediate datapath registers; qualified by the valid bits, so no reset.
    always_ff @(posedge clk) begin
        if (adv) begin
            top_p0_q   <= top_p0_d;
            bot_p0_q   <= bot_p0_d;
            yfrac_p0_q <= yfrac_p0_d;
            acc_p1_q   <= acc_p1_d;
        end
    end

endmodule

// File: tb/tb_bilinear_interp.sv
// Scoreboard bench for bilinear_interp (img_width=16, FRAC_W=4).
// The driver pushes the hand-computed expected pixel when a sample is
// accepted. The monitor pops the expected pixel on each output handshake.
module tb_bilinear_interp;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] lu = 8'd0, ru = 8'd0, ld = 8'd0, rd = 8'd0;
    logic [3:0] xfrac = 4'd0, yfrac = 4'd0;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic       m_tlast;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int out_cnt = 0;

    bilinear_interp #(.img_width(16), .FRAC_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .lu(lu), .ru(ru), .ld(ld), .rd(rd), .xfrac(xfrac), .yfrac(yfrac),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Present one sample until accepted, pushing its expected pixel on acceptance.
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d,
                        input logic [3:0] xf, input logic [3:0] yf,
                        input logic [7:0] expv);
        bit ok = 0;
        bit rdy;
        in_valid = 1'b1;
        lu = a; ru = b; ld = c; rd = d; xfrac = xf; yfrac = yf;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            rdy = in_ready;
            if (rdy) exp_q.push_back(expv);
            @(posedge clk);
            #1;
            if (rdy) ok = 1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: scoreboard compare, stall stability and in_ready checks.
    initial begin : monitor
        bit         prev_stall = 0;
        logic [7:0] prev_data = 8'd0;
        logic       prev_last = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                out_cnt = 0;
                prev_stall = 0;
            end else begin
                check("in_ready", int'(in_ready), int'(!(m_tvalid && !m_tready)));
                if (prev_stall) begin
                    check("stall_valid", int'(m_tvalid), 1);
                    check("stall_data", int'(m_tdata), int'(prev_data));
                    check("stall_last", int'(m_tlast), int'(prev_last));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", int'(m_tdata), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("data", int'(m_tdata), int'(e));
                        check("tlast", int'(m_tlast), int'(out_cnt % 16 == 15));
                    end
                    out_cnt++;
                end
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
                prev_last  = m_tlast;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        // Reset state.
        #12;
        check("rst_tvalid", int'(m_tvalid), 0);
        check("rst_tdata", int'(m_tdata), 0);
        check("rst_tlast", int'(m_tlast), 0);
        check("rst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // lu=37 passes straight through with 3-cycle latency.
        send(8'd37, 8'd0, 8'd0, 8'd0, 4'd0, 4'd0, 8'd37);
        @(posedge clk);
        #1;
        check("lat_early_valid", int'(m_tvalid), 0);
        @(posedge clk);
        #1;
        check("lat_valid", int'(m_tvalid), 1);
        check("lat_data", int'(m_tdata), 37);
        drain();

        // Half-way horizontal blend: 127.5.
`ifdef BILINEAR_ROUND_EN
        send(8'd0, 8'd255, 8'd0, 8'd255, 4'd8, 4'd0, 8'd128);
        send(8'd100, 8'd200, 8'd50, 8'd150, 4'd4, 4'd12, 8'd88);
        send(8'd0, 8'd0, 8'd0, 8'd200, 4'd15, 4'd15, 8'd176);
`else
        send(8'd0, 8'd255, 8'd0, 8'd255, 4'd8, 4'd0, 8'd127);
        send(8'd100, 8'd200, 8'd50, 8'd150, 4'd4, 4'd12, 8'd87);
        send(8'd0, 8'd0, 8'd0, 8'd200, 4'd15, 4'd15, 8'd175);
`endif
        // Full-scale corner: 255 without wrap.
        send(8'd255, 8'd255, 8'd255, 8'd255, 4'd15, 4'd15, 8'd255);
        send(8'd10, 8'd20, 8'd30, 8'd40, 4'd0, 4'd8, 8'd20);
        drain();

        // Ramp of 20 with m_tready low for cycles 5-9.
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [7:0] v;
                    v = 8'(i * 7 + 3);
                    send(v, v, v, v, 4'(i), 4'(3 * i), v);
                end
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    m_tready = !(c >= 5 && c <= 9);
                    @(posedge clk);
                    #1;
                end
                m_tready = 1'b1;
            end
        join
        drain();

        // Mid-stream reset with 3 samples in flight.
        m_tready = 1'b0;
        send(8'd11, 8'd11, 8'd11, 8'd11, 4'd0, 4'd0, 8'd11);
        send(8'd12, 8'd12, 8'd12, 8'd12, 4'd0, 4'd0, 8'd12);
        send(8'd13, 8'd13, 8'd13, 8'd13, 4'd0, 4'd0, 8'd13);
        rst = 1'b0;
        #1;
        check("midrst_tvalid", int'(m_tvalid), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_tready = 1'b1;
        send(8'd99, 8'd99, 8'd99, 8'd99, 4'd5, 4'd9, 8'd99);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("post_rst_valid", int'(m_tvalid), 1);
        check("post_rst_data", int'(m_tdata), 99);
        check("post_rst_last", int'(m_tlast), 0);
        drain();

        // 40 continuous pixels from column 0: tlast on outputs 15 and 31.
        pulse_reset();
        for (int i = 0; i < 40; i++) begin
            logic [7:0] v;
            v = 8'(200 - i);
            send(v, v, v, v, 4'(i), 4'(15 - (i % 16)), v);
        end
        drain();
        check("row_out_count", out_cnt, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
